// File: rtl/div_pkg.sv
// Shared widths, state encoding and divide-by-zero quotient for the sequential divider.
package div_pkg;
  localparam int DIV_N = 4;
  localparam int DIV_W = 2 * DIV_N;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  localparam logic [DIV_W-1:0] QUOT_DBZ = {DIV_W{1'b1}};
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract y if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   rem_i,
  input  logic         bit_i,
  input  logic [N-1:0] y_i,
  output logic [N:0]   rem_o,
  output logic         qbit_o
);

  logic [N+1:0] shifted;
  logic [N+1:0] diff;

  // rem_i is always below y, so the shifted value fits in N+1 bits; the extra bit keeps the compare exact.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, y_i};
    qbit_o  = (shifted >= {2'b00, y_i});
    rem_o   = (N+1)'(qbit_o ? diff : shifted);
  end

endmodule

// File: rtl/divider_seq.sv
// Iterative unsigned restoring divider (2N-bit dividend / N-bit divisor) with valid/ready handshakes.
// Define DIVIDER_SEQ_RADIX4_EN to retire two quotient bits per cycle.
module divider_seq
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] x,
  input  logic [N-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r,
  output logic           err
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(W);

  state_e        state_q, state_d;
  logic [N:0]    rem_q, rem_d, remNext;
  logic [W-1:0]  quot_q, quot_d, quotNext;
  logic [N-1:0]  y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d, cntStart;
  logic          err_q, err_d;

`ifdef DIVIDER_SEQ_RADIX4_EN
  logic [N:0] remMid;
  logic       qBit0, qBit1;

  div_step #(.N(N)) u_step0 (
    .rem_i (rem_q),
    .bit_i (quot_q[W-1]),
    .y_i   (y_q),
    .rem_o (remMid),
    .qbit_o(qBit0)
  );

  div_step #(.N(N)) u_step1 (
    .rem_i (remMid),
    .bit_i (quot_q[W-2]),
    .y_i   (y_q),
    .rem_o (remNext),
    .qbit_o(qBit1)
  );

  assign quotNext = {quot_q[W-3:0], qBit0, qBit1};
  assign cntStart = CW'(N - 1);
`else
  logic qBit0;

  div_step #(.N(N)) u_step0 (
    .rem_i (rem_q),
    .bit_i (quot_q[W-1]),
    .y_i   (y_q),
    .rem_o (remNext),
    .qbit_o(qBit0)
  );

  assign quotNext = {quot_q[W-2:0], qBit0};
  assign cntStart = CW'(W - 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quot_q  <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // The quotient register doubles as the dividend shifter: its MSB feeds the next step.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          y_d = y;
          if (y == '0) begin
            quot_d  = W'(QUOT_DBZ);
            rem_d   = {1'b0, x[N-1:0]};
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            quot_d  = x;
            rem_d   = '0;
            err_d   = 1'b0;
            cnt_d   = cntStart;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d  = remNext;
        quot_d = quotNext;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is masked by rst_n so it stays low for the whole reset pulse.
  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign q         = quot_q;
  assign r         = rem_q[N-1:0];
  assign err       = err_q;

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Iterative unsigned divider; the inverse of the team's combinational 4b×4b array multiplier.
- Takes a 2N-bit dividend x and an N-bit divisor y. Returns a 2N-bit quotient q and an N-bit remainder r such that x = q*y + r, with r < y.
- Restoring division, one quotient bit per cycle, with valid/ready handshakes on input and output.
- Used to check multiplier outputs end to end (divide a product by one operand) and as a standalone arithmetic unit.

Parameters:
- N, 4, divisor width, remainder width, and half the dividend/quotient width.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands x, y valid
- in_ready  output  1  divider can accept operands
- x  input  2N  dividend, unsigned
- y  input  N  divisor, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- q  output  2N  quotient
- r  output  N  remainder
- err  output  1  divide-by-zero flag, qualified by out_valid

Behaviour:
- Reset values: in_ready=0 while rst_n low, then 1 in IDLE; out_valid=0, q=0, r=0, err=0. All internal registers clear. Counter=0, state=IDLE.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch x and y; x and y are ignored after acceptance.
  - IDLE → CALC when y≠0. Partial remainder (N+1 bits) is cleared, the quotient register is loaded with x, and the counter is set to 2N-1.
  - IDLE → DONE when y=0, producing err=1, q={2N{1}}, r=x[N-1:0].
  - CALC: in_ready=0. Each cycle:
    - shift {rem, quot} left by 1;
    - trial = rem - {0,y};
    - if trial is non-negative, rem=trial and quot LSB=1, else quot LSB=0.
  - CALC → DONE on the step taken with counter=0. Otherwise decrement the counter.
  - DONE: out_valid=1. q, r and err are held stable until out_ready=1.
  - DONE → IDLE on out_valid&&out_ready, which also clears out_valid.
- Latency:
  - Normal operation: out_valid rises on the 2N-th rising edge after the accepting edge (8 for N=4).
  - Divide-by-zero: out_valid rises on the first edge after acceptance.
- Throughput: no new operand is accepted until the result is taken. in_ready is low in CALC and DONE.
- Handshake rules:
  - out_valid must not drop without out_ready.
  - out_ready held high before out_valid rises is legal; the result is then consumed on the same cycle it appears (one DONE cycle).
  - in_ready does not depend combinationally on out_ready.
- Arithmetic: the partial remainder is held in N+1 bits to absorb the shift carry. The final r fits in N bits.
- Boundary cases:
  - y=1: q=x, r=0.
  - x<y: q=0, r=x.
  - x=0: q=0, r=0.
  - y={N{1}} with x={2N{1}}: exact, no overflow, because the quotient is 2N bits.
- Reset mid-operation: asynchronous return to IDLE; the in-flight result is discarded and no out_valid is produced.

Optional Feature:
- Macro DIVIDER_SEQ_RADIX4_EN. When defined, two restoring steps are chained per cycle: the counter starts at N-1 and normal latency becomes N edges (4 for N=4).
- Results, divide-by-zero behaviour and handshakes are identical with or without the macro.
- When undefined, the divider runs one bit per cycle as above.

Decomposition:
- Shared package div_pkg holds:
  - width constants DIV_N, DIV_W=2*DIV_N;
  - the state enum {S_IDLE, S_CALC, S_DONE};
  - the divide-by-zero constant QUOT_DBZ={DIV_W{1}}.
- Sub-module div_step: a combinational single restoring step. Inputs are rem, the incoming dividend bit and y; outputs are the new rem and a quotient bit.
- div_step is instantiated once normally and twice (chained) under DIVIDER_SEQ_RADIX4_EN.

Test Plan:
- x=200, y=7 → after 8 edges (4 in radix-4 mode), out_valid=1, q=28, r=4, err=0.
- x=255, y=1 → q=255, r=0. Then x=3, y=15 → q=0, r=3. Then x=0, y=9 → q=0, r=0.
- x=15, y=0 → out_valid on the first edge after acceptance, err=1, q=255, r=15.
- x=100, y=9 with out_ready=0 for 5 cycles after out_valid → q=11, r=1 held stable, in_ready=0 throughout; IDLE is reached one edge after out_ready=1.
- Assert rst_n=0 at the 3rd CALC cycle, then release and apply x=64, y=8 → no stale out_valid; q=8, r=0.
- Exhaustive sweep of all 256×16 operand pairs with random in_valid and out_ready stalls → every result satisfies q*y+r=x and r<y; every y=0 case gives err=1.
